mux_arb_nway: RTL
=================

# mux_arb_nway

N-input, WIDTH-bit arbitrated multiplexer with a valid/ready handshake on every input and a single registered output stage. It generalises the team's combinational 2:1 word mux to N channels: instead of a caller-driven select, it arbitrates among requesting inputs and holds the selected word until the consumer takes it. It sits between multiple producers (register-file write sources, game-logic event sources) and one shared consumer.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- N, 4, number of input channels (≥2)
- SEL_W, clog2(N), width of channel index; derived, not overridden
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  channel i offers a word
- in_ready  out  N  channel i's word is accepted this cycle (one-hot or zero)
- out_data  out  WIDTH  registered selected word
- out_sel  out  SEL_W  index of the channel that supplied out_data
- out_valid  out  1  out_data/out_sel hold a word
- out_ready  in  1  consumer takes the word this cycle

## Operation
- Output register is a two-state FSM: EMPTY (out_valid=0), FULL (out_valid=1).
- load_en = !out_valid || out_ready; transfer out = out_valid && out_ready.
- grant = arbitration winner among in_valid bits; in_ready[grant] = load_en && |in_valid; all other in_ready bits are 0.
- in_ready depends combinationally on in_valid and out_ready. Producers must not make in_valid depend on in_ready.
- On load: out_data <= selected word, out_sel <= grant, out_valid <= 1.
- load_en && !|in_valid: out_valid <= 0 (if draining), out_data/out_sel hold their last values.
- FULL && !out_ready: all outputs hold, all in_ready are 0.
- Simultaneous drain and load: the new word replaces the old one in the same edge. Throughput is 1 word/cycle with no bubble.
- Round-robin pointer ptr (SEL_W bits): search starts at ptr and wraps upward through N-1 to 0. After an accept from channel g, ptr <= (g==N-1) ? 0 : g+1. With no accept, ptr holds.
- Non-power-of-2 N: indices ≥N are never granted, and ptr wraps at N-1.
- Reset mid-transfer: the word in the output register is discarded. There is no in_ready during the reset cycle.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready=0 while reset is high.
- Latency: accept at edge k; out_valid/out_data are visible after edge k; earliest drain is at edge k+1.
- Fairness: with all N channels continuously valid and out_ready=1, each channel is granted exactly once every N cycles.
- in_ready is asserted in the same cycle as the handshake, with no registered lookahead.

## Configuration
- MUX_ARB_RR_EN defined: round-robin arbitration as described above.
- MUX_ARB_RR_EN undefined: fixed priority, where the lowest valid index wins and ptr is not implemented. out_sel and handshake behaviour are otherwise identical.

## Structure
- Shared package mux_pkg: MUX_DEFAULT_WIDTH=32, MUX_DEFAULT_N=4, and a clog2 constant function used for SEL_W.
- One sub-module, mux_rr_pick:
  - inputs: N-bit request and SEL_W-bit start index;
  - outputs: SEL_W-bit grant and any-valid flag;
  - purely combinational;
  - tied to start=0 when MUX_ARB_RR_EN is undefined.
- mux_arb_nway holds the output register, the FSM and ptr.

## Test plan
- Reset: hold reset 2 cycles with in_valid=4'b1111 → out_valid=0, out_data=0, out_sel=0, in_ready=0. First accept after release comes from channel 0.
- Round-robin: N=4, all valid, data_i=32'hA0+i, out_ready=1 → out_sel sequence 0,1,2,3,0, one word per cycle with no bubble.
- Backpressure: load channel 2 (32'hDEAD), hold out_ready=0 for 5 cycles with in_valid=4'b1011 → out_data stays 32'hDEAD and in_ready=0 throughout. On release, channel 3 is granted next.
- Drain and load together: FULL with out_ready=1 and in_valid=4'b0001 → word replaced in one edge. out_valid stays 1 and out_sel=0.
- Idle drain: FULL, out_ready=1, in_valid=0 → out_valid=0 next cycle and out_data holds its value.
- Build without MUX_ARB_RR_EN, all valid → out_sel=0 every cycle. Build with N=3 → ptr wraps 2→0 and index 3 is never granted.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared defaults, output-stage state encoding and the channel-index width helper
// for the arbitrated N-way multiplexer.
package mux_pkg;

   localparam int MUX_DEFAULT_WIDTH = 32;
   localparam int MUX_DEFAULT_N     = 4;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } mux_state_e;

   // Minimum bits to index v channels; returns at least 1 for v >= 2.
   function automatic int mux_clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Combinational picker: first requesting index found searching upward from i_start,
// wrapping at N-1. Indices >= N are never visited.
module mux_rr_pick import mux_pkg::*; #(
   parameter int N     = MUX_DEFAULT_N,
   parameter int SEL_W = mux_clog2(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [SEL_W-1:0] i_start,
   output logic [SEL_W-1:0] o_grant,
   output logic             o_any
);

   int w_idx;

   // Walk from the farthest candidate back to the start so the nearest one wins.
   always_comb begin
      o_grant = '0;
      w_idx   = 0;
      for (int k = N - 1; k >= 0; k--) begin
         w_idx = int'(i_start) + k;
         if (w_idx >= N) w_idx = w_idx - N;
         if (i_req[w_idx]) o_grant = w_idx[SEL_W-1:0];
      end
   end

   assign o_any = |i_req;

endmodule

// File: rtl/mux_arb_nway.sv
// N-input arbitrated multiplexer with valid/ready per channel and one registered output stage.
// Define MUX_ARB_RR_EN for round-robin arbitration; otherwise lowest valid index wins.
module mux_arb_nway import mux_pkg::*; #(
   parameter int WIDTH = MUX_DEFAULT_WIDTH,
   parameter int N     = MUX_DEFAULT_N
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic [N*WIDTH-1:0]       i_in_data,
   input  logic [N-1:0]             i_in_valid,
   output logic [N-1:0]             o_in_ready,
   output logic [WIDTH-1:0]         o_out_data,
   output logic [mux_clog2(N)-1:0]  o_out_sel,
   output logic                     o_out_valid,
   input  logic                     i_out_ready
);

   localparam int SEL_W = mux_clog2(N);

   mux_state_e       r_state, w_state_nxt;
   logic [WIDTH-1:0] r_data;
   logic [SEL_W-1:0] r_sel;
   logic [SEL_W-1:0] w_start, w_grant;
   logic             w_any, w_load_en, w_accept;

`ifdef MUX_ARB_RR_EN
   logic [SEL_W-1:0] r_ptr;

   always_ff @(posedge i_clock) begin
      if (i_reset)       r_ptr <= '0;
      else if (w_accept) r_ptr <= (w_grant == SEL_W'(N - 1)) ? '0 : w_grant + 1'b1;
   end

   assign w_start = r_ptr;
`else
   assign w_start = '0;
`endif

   mux_rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
      .i_req   (i_in_valid),
      .i_start (w_start),
      .o_grant (w_grant),
      .o_any   (w_any)
   );

   assign w_load_en = (r_state == ST_EMPTY) || i_out_ready;
   // Reset suppresses acceptance so no producer believes a word was taken.
   assign w_accept  = w_load_en && w_any && !i_reset;

   always_comb begin
      o_in_ready = '0;
      if (w_accept) o_in_ready[w_grant] = 1'b1;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_load_en) w_state_nxt = w_any ? ST_FULL : ST_EMPTY;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= ST_EMPTY;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_data <= '0;
         r_sel  <= '0;
      end else if (w_accept) begin
         r_data <= i_in_data[w_grant*WIDTH +: WIDTH];
         r_sel  <= w_grant;
      end
   end

   assign o_out_data  = r_data;
   assign o_out_sel   = r_sel;
   assign o_out_valid = (r_state == ST_FULL);

endmodule
